data_control_test: RTL and testbench

//  4-bit GCD engine (subtract-and-compare algorithm): an FSM controller plus a

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_if.sv | 29 ++
 rtl/gcd_datapath.sv | 38 +++
 rtl/data_control_test.sv | 108 ++++++++++
 tb/tb_data_control_test.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared constants and state encoding for the 4-bit GCD engine.
package gcd_pkg;

  localparam int GCD_W = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_CMP   = 4'd2,
    S_LT    = 4'd3,
    S_YSUB  = 4'd4,
    S_XSUB  = 4'd5,
    S_WRITE = 4'd6,
    S_DONE  = 4'd7
  } state_e;

endpackage

// File: rtl/gcd_if.sv
// Controller/datapath handshake: operand inputs, mux selects and write
// enables flow from the controller, comparator status and registers flow back.
interface gcd_if;
  import gcd_pkg::*;

  logic [GCD_W-1:0] x_i;
  logic [GCD_W-1:0] y_i;
  logic             x_sel;
  logic             y_sel;
  logic             x_write;
  logic             y_write;
  logic             d_write;
  logic             x_neq_y;
  logic             x_lt_y;
  logic [GCD_W-1:0] x_reg;
  logic [GCD_W-1:0] y_reg;
  logic [GCD_W-1:0] d_reg;

  modport ctrl (
    output x_i, y_i, x_sel, y_sel, x_write, y_write, d_write,
    input  x_neq_y, x_lt_y, x_reg, y_reg, d_reg
  );

  modport dp (
    input  x_i, y_i, x_sel, y_sel, x_write, y_write, d_write,
    output x_neq_y, x_lt_y, x_reg, y_reg, d_reg
  );

endinterface

// File: rtl/gcd_datapath.sv
// GCD datapath: x/y/d registers, load-or-subtract muxes and comparators.
module gcd_datapath
  import gcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  gcd_if.dp    bus
);

  logic [GCD_W-1:0] x_q, y_q, d_q;
  logic [GCD_W-1:0] x_d, y_d;

  // Operand muxes: fresh operand on load, difference on subtract.
  always_comb begin
    x_d = bus.x_sel ? (x_q - y_q) : bus.x_i;
    y_d = bus.y_sel ? (y_q - x_q) : bus.y_i;
  end

  // Operand and result registers; result is x|y so a zero operand passes the other through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      d_q <= '0;
    end else begin
      if (bus.x_write) x_q <= x_d;
      if (bus.y_write) y_q <= y_d;
      if (bus.d_write) d_q <= x_q | y_q;
    end
  end

  assign bus.x_neq_y = (x_q != y_q);
  assign bus.x_lt_y  = (x_q < y_q);
  assign bus.x_reg   = x_q;
  assign bus.y_reg   = y_q;
  assign bus.d_reg   = d_q;

endmodule

// File: rtl/data_control_test.sv
// GCD engine top: Moore FSM controller driving gcd_datapath, all handshake visible.
//
//  state   | meaning
//  S_IDLE  | wait for go_i
//  S_LOAD  | capture x_i / y_i
//  S_CMP   | zero or equal operands -> finish, else compare magnitude
//  S_LT    | pick which operand to reduce
//  S_YSUB  | y_reg <= y_reg - x_reg
//  S_XSUB  | x_reg <= x_reg - y_reg
//  S_WRITE | d_reg <= x_reg | y_reg
//  S_DONE  | result valid; leave once go_i drops
module data_control_test
  import gcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [GCD_W-1:0] x_i,
  input  logic [GCD_W-1:0] y_i,
  input  logic             go_i,
  output logic [3:0]       state,
  output logic             x_neq_y,
  output logic             x_lt_y,
  output logic             x_sel,
  output logic             y_sel,
  output logic             x_write,
  output logic             y_write,
  output logic             d_write,
  output logic [GCD_W-1:0] GCD_OUT,
  output logic             DONE,
  output logic [GCD_W-1:0] x_dff_out,
  output logic [GCD_W-1:0] y_dff_out
);

  state_e state_q, state_d;

  gcd_if bus ();

  gcd_datapath u_dp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.x_i     = x_i;
  assign bus.y_i     = y_i;
  assign bus.x_sel   = x_sel;
  assign bus.y_sel   = y_sel;
  assign bus.x_write = x_write;
  assign bus.y_write = y_write;
  assign bus.d_write = d_write;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore output decode; selects only rise with their write enable.
  always_comb begin
    state_d = state_q;
    x_sel   = 1'b0;
    y_sel   = 1'b0;
    x_write = 1'b0;
    y_write = 1'b0;
    d_write = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      S_IDLE:  if (go_i) state_d = S_LOAD;
      S_LOAD: begin
        x_write = 1'b1;
        y_write = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (bus.x_reg == '0 || bus.y_reg == '0 || !bus.x_neq_y) state_d = S_WRITE;
        else                                                     state_d = S_LT;
      end
      S_LT:    state_d = bus.x_lt_y ? S_YSUB : S_XSUB;
      S_YSUB: begin
        y_sel   = 1'b1;
        y_write = 1'b1;
        state_d = S_CMP;
      end
      S_XSUB: begin
        x_sel   = 1'b1;
        x_write = 1'b1;
        state_d = S_CMP;
      end
      S_WRITE: begin
        d_write = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (!go_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state     = state_q;
  assign x_neq_y   = bus.x_neq_y;
  assign x_lt_y    = bus.x_lt_y;
  assign GCD_OUT   = bus.d_reg;
  assign x_dff_out = bus.x_reg;
  assign y_dff_out = bus.y_reg;

endmodule

// File: tb/tb_data_control_test.sv
// Self-checking bench for the GCD engine: vector table, corner sequences, sweep and random runs.
module tb_data_control_test;
  import gcd_pkg::*;

  logic       clk;
  logic       reset;
  logic       go_i;
  logic [3:0] state;
  logic       DONE;

  gcd_if bus ();

  data_control_test dut (
    .clk       (clk),
    .reset     (reset),
    .x_i       (bus.x_i),
    .y_i       (bus.y_i),
    .go_i      (go_i),
    .state     (state),
    .x_neq_y   (bus.x_neq_y),
    .x_lt_y    (bus.x_lt_y),
    .x_sel     (bus.x_sel),
    .y_sel     (bus.y_sel),
    .x_write   (bus.x_write),
    .y_write   (bus.y_write),
    .d_write   (bus.d_write),
    .GCD_OUT   (bus.d_reg),
    .DONE      (DONE),
    .x_dff_out (bus.x_reg),
    .y_dff_out (bus.y_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel_bad = 0;
  int xs[$];
  int ys[$];

  typedef struct {
    int x;
    int y;
    int exp_g;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtraction count equals the sum of Euclid quotients minus the final equal step.
  function automatic int ref_lat(input int a, input int b);
    int s, t;
    if (a == 0 || b == 0) return 4;
    s = 0;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return 4 + 3 * (s - 1);
  endfunction

  // Starts in IDLE just after an edge; returns with go_i still high, DONE seen (or budget spent).
  task automatic run_gcd(input int a, input int b, output int cyc, output bit sub_seen);
    bit prev_xw, prev_yw;
    bus.x_i = 4'(a);
    bus.y_i = 4'(b);
    go_i = 1'b1;
    cyc = 0;
    sub_seen = 0;
    prev_xw = 0;
    prev_yw = 0;
    xs.delete();
    ys.delete();
    while (cyc < 100) begin
      step();
      cyc++;
      if (prev_xw) xs.push_back(int'(bus.x_reg));
      if (prev_yw) ys.push_back(int'(bus.y_reg));
      prev_xw = bus.x_write;
      prev_yw = bus.y_write;
      if (state == 4'd4 || state == 4'd5) sub_seen = 1;
      if ((!bus.x_write && bus.x_sel) || (!bus.y_write && bus.y_sel)) sel_bad++;
      if (state == 4'd2) begin
        bus.x_i = 4'($urandom);
        bus.y_i = 4'($urandom);
      end
      if (DONE) break;
    end
  endtask

  task automatic finish_run();
    go_i = 1'b0;
    step();
  endtask

  vec_t vecs[7];
  int   cyc;
  bit   sub_seen;
  int   a, b, tmo;

  initial begin
    vecs[0] = '{12, 9, 3, 13};
    vecs[1] = '{9, 8, 1, 28};
    vecs[2] = '{7, 7, 7, 4};
    vecs[3] = '{0, 5, 5, 4};
    vecs[4] = '{6, 0, 6, 4};
    vecs[5] = '{0, 0, 0, 4};
    vecs[6] = '{15, 1, 1, 46};

    reset = 1'b0;
    go_i = 1'b0;
    bus.x_i = 4'd0;
    bus.y_i = 4'd0;
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rst_state", int'(state), 0);
    check("rst_gcd", int'(bus.d_reg), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_en", int'({bus.x_sel, bus.y_sel, bus.x_write, bus.y_write, bus.d_write}), 0);
    check("rst_xy", int'({bus.x_reg, bus.y_reg}), 0);

    // Vector table.
    foreach (vecs[i]) begin
      run_gcd(vecs[i].x, vecs[i].y, cyc, sub_seen);
      check($sformatf("vec%0d_lat", i), cyc, vecs[i].exp_lat);
      check($sformatf("vec%0d_gcd", i), int'(bus.d_reg), vecs[i].exp_g);
      if (vecs[i].x == vecs[i].y) check("equal_no_sub", int'(sub_seen), 0);
      finish_run();
      check($sformatf("vec%0d_idle", i), int'(state), 0);
    end

    // (12,9) register trace, then hold go_i in DONE.
    run_gcd(12, 9, cyc, sub_seen);
    check("trace_x_len", xs.size(), 2);
    check("trace_y_len", ys.size(), 3);
    if (xs.size() == 2) begin
      check("trace_x0", xs[0], 12);
      check("trace_x1", xs[1], 3);
    end
    if (ys.size() == 3) begin
      check("trace_y0", ys[0], 9);
      check("trace_y1", ys[1], 6);
      check("trace_y2", ys[2], 3);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_done_state", int'(state), 7);
      check("hold_done_flag", int'(DONE), 1);
    end
    finish_run();
    check("hold_release_idle", int'(state), 0);
    check("hold_gcd_kept", int'(bus.d_reg), 3);
    step();
    check("idle_gcd_kept", int'(bus.d_reg), 3);

    // Reset during S_YSUB, then a clean run.
    bus.x_i = 4'd12;
    bus.y_i = 4'd9;
    go_i = 1'b1;
    tmo = 0;
    while (state != 4'd4 && tmo < 50) begin
      step();
      tmo++;
    end
    check("reach_ysub", int'(state), 4);
    #2;
    reset = 1'b0;
    #1;
    check("abort_state", int'(state), 0);
    check("abort_regs", int'({bus.x_reg, bus.y_reg, bus.d_reg}), 0);
    check("abort_done", int'(DONE), 0);
    go_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    run_gcd(10, 4, cyc, sub_seen);
    check("post_abort_lat", cyc, 13);
    check("post_abort_gcd", int'(bus.d_reg), 2);
    finish_run();

    // Full nonzero sweep with random idle gaps.
    for (int i = 1; i < 16; i++) begin
      for (int j = 1; j < 16; j++) begin
        repeat ($urandom_range(0, 2)) step();
        run_gcd(i, j, cyc, sub_seen);
        check($sformatf("sweep_%0d_%0d_lat", i, j), cyc, ref_lat(i, j));
        check($sformatf("sweep_%0d_%0d_gcd", i, j), int'(bus.d_reg), ref_gcd(i, j));
        finish_run();
      end
    end

    // Random operands including zeros.
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      run_gcd(a, b, cyc, sub_seen);
      check($sformatf("rand_%0d_%0d_lat", a, b), cyc, ref_lat(a, b));
      check($sformatf("rand_%0d_%0d_gcd", a, b), int'(bus.d_reg), ref_gcd(a, b));
      finish_run();
      check("rand_idle", int'(state), 0);
    end

    check("sel_gated", sel_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
